uart_rx: RTL
============

# uart_rx

Serial receiver for the configurable UART, the counterpart of `uart_tx`. It recovers a frame from the `rx` line using the 16x oversampling `s_tick` from `baud_generator`, and it accepts the same runtime frame-format selects as the transmitter. Each frame produces the data word, a one-cycle done pulse and parity/framing error flags for the host logic. Any `uart_tx` setting can be looped back into this block.

## Interface
Parameters:
- `OVERSAMPLE`, default 16: `s_tick` pulses per bit. Fixed at 16; the tick thresholds below assume it.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `s_tick`  in  1: one-`clk` enable pulse at 16x the baud rate.
- `rx`  in  1: asynchronous serial line; idles high.
- `dbit_select_i`  in  3: data bits. 000→5, 001→6, 010→7, 011→8; 1xx is treated as 8.
- `sbit_select_i`  in  2: stop bits. 00→1, 01→1.5, 10→2; 11 is treated as 1.
- `parity_select_i`  in  2: parity. 00→none, 01→even, 10→odd; 11 is treated as none.
- `rx_dout`  out  8: received data, right-justified, unused upper bits 0.
- `rx_done_tick`  out  1: one-`clk` pulse when a frame completes.
- `parity_err`  out  1: parity mismatch on the last frame.
- `frame_err`  out  1: a stop bit was sampled low on the last frame.
- `rx_busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- **Input synchronizer:** `rx` passes through a 2-FF synchronizer, both flops reset to 1. All logic uses the synchronized value `rx_s`.
- **Config latch:** the three select inputs are latched on the IDLE→START transition. Changes mid-frame are ignored.
- **Tick counter:** `t` is 5 bits, advances only on `s_tick`, and clears on every state change.
- **Bit counter:** `n` is 3 bits and counts data bits.
- **IDLE:** when `rx_s==0`, go to START and clear `t`.
- **START:** at `t==7` (mid start bit):
  - if `rx_s==0`, go to DATA and clear `t` and `n`;
  - otherwise it is a false start: return to IDLE with no outputs changed.
- **DATA:** at `t==15`, shift `rx_s` in LSB-first and compute the running XOR.
  - If `n==dbits-1`, go to PARITY when parity is enabled, otherwise to STOP.
  - Otherwise increment `n`.
- **PARITY:** at `t==15`, sample the parity bit, then go to STOP.
  - Expected bit is XOR(data) for even, ~XOR(data) for odd.
- **STOP:** `t` counts from the middle of the previous bit.
  - Sample at `t==15`, and also at `t==31` when 2 stop bits are selected.
  - Any low sample sets the frame-error candidate.
  - At `t==SB-1` (SB = 16/24/32 for 1/1.5/2 stop bits), go to IDLE and assert `rx_done_tick`.
- **Output update:** `rx_dout`, `parity_err` and `frame_err` update in the same `clk` as `rx_done_tick`. They hold until the next done pulse.
  - `parity_err` is 0 when parity is none.
- **Break condition** (line held low): the frame completes with `rx_dout=0` and `frame_err=1`. The FSM re-enters START immediately while the line stays low.

## Timing
- **Reset values:** `rx_dout=0`, `rx_done_tick=0`, `parity_err=0`, `frame_err=0`, `rx_busy=0`. FSM in IDLE, synchronizer flops 1.
- **Reset mid-frame:** the frame is abandoned with no done pulse. Receive resumes from IDLE on the first low `rx_s` after reset.
- **Latency:**
  - 2 `clk` from an `rx` edge to `rx_s`.
  - `rx_done_tick` is registered: it asserts in the `clk` after the `s_tick` that reaches `t==SB-1`.
  - 8-N-1 frame: the done pulse lands about 9.5 bit times after the start falling edge.
- **Back-to-back frames:** supported. IDLE is reached by the middle of the stop bit, so a start edge right after the stop bit is caught.
- **Handshake:** there is none and no backpressure. The host must consume `rx_dout` before the next `rx_done_tick`, or it is overwritten.
- **`rx_busy`:** registered and equal to (state≠IDLE).

## Structure
- **Shared header `uart_defs.vh`** (also included by `uart_tx`):
  - select encodings (DBIT_5..8, SBIT_1/1_5/2, PAR_NONE/EVEN/ODD);
  - oversample constant 16;
  - stop-tick counts 16/24/32.
- **FSM state encoding** is local to `uart_rx`.
- **Sub-module `uart_sync2`:** a 2-FF synchronizer with a reset-value parameter, reusable for other asynchronous inputs.

## Test plan
All scenarios use 100 MHz `clk`, `baud_generator` with `baud_rate_sel=8`, and `uart_tx` looped back into `rx` with identical selects.
- **8-N-1, 0xAC:** `rx_dout=8'hAC`, `parity_err=0`, `frame_err=0`, exactly one `rx_done_tick`.
- **7-E-2, 0x55:** `rx_dout=8'h55`, `parity_err=0`. Then drive `rx` directly with the parity bit inverted: `parity_err=1`, `rx_dout=8'h55`.
- **Format sweep:**
  - 8-O-1.5, 0xF0: `rx_dout=8'hF0`, no errors.
  - 5-N-1, 0x15: `rx_dout=8'h15`.
  - 6-E-1, 0x2A: `rx_dout=8'h2A`, no errors.
- **Back-to-back 8-N-1, 0xAA then 0x55:** two done pulses, `rx_dout` 8'hAA then 8'h55, no errors.
- **Glitch and break:**
  - A 3-tick low pulse on idle `rx` gives no done pulse and `rx_busy` returns to 0.
  - `rx` held low for 12 bit times gives `rx_dout=0`, `frame_err=1`.
- **Reset mid-frame:** `reset` asserted halfway through the data bits gives all outputs 0 and no done pulse. The next clean frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: select encodings, oversample/stop constants
// and the decoder that turns raw select inputs into a latched frame config.
package uart_rx_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  localparam logic [2:0] DBIT_5   = 3'b000;
  localparam logic [2:0] DBIT_6   = 3'b001;
  localparam logic [2:0] DBIT_7   = 3'b010;
  localparam logic [2:0] DBIT_8   = 3'b011;

  localparam logic [1:0] SBIT_1   = 2'b00;
  localparam logic [1:0] SBIT_1_5 = 2'b01;
  localparam logic [1:0] SBIT_2   = 2'b10;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int STOP_TICKS_1   = 16;
  localparam int STOP_TICKS_1_5 = 24;
  localparam int STOP_TICKS_2   = 32;

  typedef enum logic [1:0] {PM_NONE, PM_EVEN, PM_ODD} par_mode_e;

  typedef struct packed {
    logic [2:0] dlast;     // index of the last data bit (dbits-1)
    logic [4:0] sb_last;   // stop-state tick that ends the frame (SB-1)
    logic       two_stop;  // take a second stop sample at t==31
    par_mode_e  par;
  } rx_cfg_t;

  localparam rx_cfg_t CFG_RST = '{dlast: 3'd7, sb_last: 5'd15, two_stop: 1'b0, par: PM_NONE};

  function automatic rx_cfg_t decode_cfg(input logic [2:0] dsel,
                                         input logic [1:0] ssel,
                                         input logic [1:0] psel);
    rx_cfg_t c;
    c = CFG_RST;
    case (dsel)
      DBIT_5:  c.dlast = 3'd4;
      DBIT_6:  c.dlast = 3'd5;
      DBIT_7:  c.dlast = 3'd6;
      default: c.dlast = 3'd7;
    endcase
    case (ssel)
      SBIT_1_5: begin c.sb_last = 5'(STOP_TICKS_1_5 - 1); c.two_stop = 1'b0; end
      SBIT_2:   begin c.sb_last = 5'(STOP_TICKS_2 - 1);   c.two_stop = 1'b1; end
      default:  begin c.sb_last = 5'(STOP_TICKS_1 - 1);   c.two_stop = 1'b0; end
    endcase
    case (psel)
      PAR_EVEN: c.par = PM_EVEN;
      PAR_ODD:  c.par = PM_ODD;
      default:  c.par = PM_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is
// a parameter so idle-high and idle-low lines can both use it.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta, r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/parity/stop recovery with runtime
// frame format, registered data, done pulse and parity/framing error flags.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  input  logic [2:0] dbit_select_i,
  input  logic [1:0] sbit_select_i,
  input  logic [1:0] parity_select_i,
  output logic [7:0] rx_dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [4:0] T_MID   = 5'(OVERSAMPLE / 2 - 1);
  localparam logic [4:0] T_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] T_STOP2 = 5'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e     r_state;
  rx_cfg_t    r_cfg;
  logic [4:0] r_t;
  logic [2:0] r_n;
  logic [7:0] r_data;
  logic       r_xor;
  logic       r_par_bit;
  logic       r_ferr;
  logic [7:0] r_dout;
  logic       r_done;
  logic       r_perr_o;
  logic       r_ferr_o;
  logic       r_busy;

  logic w_rx_s;
  logic w_stop_low;
  logic w_par_exp;
  logic w_par_bad;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  // Stop samples land at the middle of each stop bit; t started mid previous bit.
  always_comb begin
    w_stop_low = 1'b0;
    if (s_tick && !w_rx_s)
      w_stop_low = (r_t == T_LAST) || (r_cfg.two_stop && (r_t == T_STOP2));
  end

  assign w_par_exp = (r_cfg.par == PM_ODD) ? ~r_xor : r_xor;
  assign w_par_bad = (r_cfg.par != PM_NONE) && (r_par_bit != w_par_exp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cfg     <= CFG_RST;
      r_t       <= '0;
      r_n       <= '0;
      r_data    <= '0;
      r_xor     <= 1'b0;
      r_par_bit <= 1'b0;
      r_ferr    <= 1'b0;
      r_dout    <= '0;
      r_done    <= 1'b0;
      r_perr_o  <= 1'b0;
      r_ferr_o  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_t     <= '0;
            r_cfg   <= decode_cfg(dbit_select_i, sbit_select_i, parity_select_i);
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (s_tick) begin
            if (r_t == T_MID) begin
              r_t <= '0;
              if (!w_rx_s) begin
                r_state <= S_DATA;
                r_n     <= '0;
                r_data  <= '0;
                r_xor   <= 1'b0;
                r_ferr  <= 1'b0;
              end else begin
                // Glitch shorter than half a bit: drop it silently.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_t <= r_t + 5'd1;
            end
          end
        end
        S_DATA: begin
          if (s_tick) begin
            if (r_t == T_LAST) begin
              r_t         <= '0;
              r_data[r_n] <= w_rx_s;
              r_xor       <= r_xor ^ w_rx_s;
              if (r_n == r_cfg.dlast)
                r_state <= (r_cfg.par != PM_NONE) ? S_PARITY : S_STOP;
              else
                r_n <= r_n + 3'd1;
            end else begin
              r_t <= r_t + 5'd1;
            end
          end
        end
        S_PARITY: begin
          if (s_tick) begin
            if (r_t == T_LAST) begin
              r_t       <= '0;
              r_par_bit <= w_rx_s;
              r_state   <= S_STOP;
            end else begin
              r_t <= r_t + 5'd1;
            end
          end
        end
        S_STOP: begin
          if (s_tick) begin
            if (r_t == r_cfg.sb_last) begin
              // The final stop sample may coincide with frame end; fold it in.
              r_state  <= S_IDLE;
              r_t      <= '0;
              r_done   <= 1'b1;
              r_dout   <= r_data;
              r_perr_o <= w_par_bad;
              r_ferr_o <= r_ferr | w_stop_low;
              r_busy   <= 1'b0;
            end else begin
              r_t <= r_t + 5'd1;
              if (w_stop_low) r_ferr <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_t     <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_dout      = r_dout;
  assign rx_done_tick = r_done;
  assign parity_err   = r_perr_o;
  assign frame_err    = r_ferr_o;
  assign rx_busy      = r_busy;

endmodule
